// File: rtl/uart_word_tx.sv
// Word-wide UART transmitter: buffers DATA_WIDTH-bit words in a small FIFO and
// sends each one least-significant byte first as 8N1-style frames (optional parity, 1-2 stops).
module uart_word_tx #(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [DATA_WIDTH-1:0]       data_in,
  output logic                        dout,
  output logic                        rdy,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LW     = AW + 1;
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CW     = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] BIT_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BYTE  = BW'(NBYTES - 1);
  localparam logic          LAST_STOP  = 1'(STOP_BITS - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [AW:0]             wptr;
  logic [AW:0]             rptr;
  logic [DATA_WIDTH-1:0]   head;
  logic                    push;
  logic                    fifo_empty;
  logic [DATA_WIDTH-1:0]   word;
  logic [CW-1:0]           bit_cnt;
  logic [2:0]              bit_idx;
  logic [BW-1:0]           byte_idx;
  logic                    stop_idx;
  logic                    par_acc;
  logic                    avail;

  // Odd parity starts the running XOR at 1 so the final value is already inverted.
  function automatic logic parity_seed();
    return (PARITY == 2);
  endfunction

  assign level      = wptr - rptr;
  assign fifo_empty = (wptr == rptr);
  assign rdy        = (level != FULL_LEVEL);
  assign busy       = (state != IDLE) || !fifo_empty;
  assign push       = en && rdy;
  assign head       = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (en && !rdy) overflow <= 1'b1;
    end
  end

  // avail delays the idle start by one cycle so the first start bit lands two
  // edges after acceptance; words queued behind a running frame start back-to-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dout     <= 1'b1;
      bit_cnt  <= '0;
      rptr     <= '0;
      word     <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      stop_idx <= 1'b0;
      par_acc  <= 1'b0;
      avail    <= 1'b0;
    end else begin
      avail <= !fifo_empty;
      if (state == IDLE) begin
        if (avail && !fifo_empty) begin
          word     <= head;
          rptr     <= rptr + 1'b1;
          byte_idx <= '0;
          dout     <= 1'b0;
          bit_cnt  <= BIT_RELOAD;
          state    <= START;
        end
      end else if (bit_cnt != '0) begin
        bit_cnt <= bit_cnt - 1'b1;
      end else begin
        bit_cnt <= BIT_RELOAD;
        case (state)
          START: begin
            dout    <= word[0];
            par_acc <= parity_seed() ^ word[0];
            word    <= word >> 1;
            bit_idx <= '0;
            state   <= DATA;
          end
          DATA: begin
            if (bit_idx == 3'd7) begin
              stop_idx <= 1'b0;
              if (PARITY != 0) begin
                dout  <= par_acc;
                state <= PAR;
              end else begin
                dout  <= 1'b1;
                state <= STOP;
              end
            end else begin
              dout    <= word[0];
              par_acc <= par_acc ^ word[0];
              word    <= word >> 1;
              bit_idx <= bit_idx + 1'b1;
            end
          end
          PAR: begin
            dout     <= 1'b1;
            stop_idx <= 1'b0;
            state    <= STOP;
          end
          STOP: begin
            if (stop_idx != LAST_STOP) begin
              stop_idx <= stop_idx + 1'b1;
            end else if (byte_idx != LAST_BYTE) begin
              byte_idx <= byte_idx + 1'b1;
              dout     <= 1'b0;
              state    <= START;
            end else if (!fifo_empty) begin
              word     <= head;
              rptr     <= rptr + 1'b1;
              byte_idx <= '0;
              dout     <= 1'b0;
              state    <= START;
            end else begin
              bit_cnt <= '0;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx: table of per-configuration frame waveforms,
// plus hand-written fill/overflow, push-with-pop and mid-frame reset sequences.
module tb_uart_word_tx;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        en0, en1, en2, en3;
  logic [31:0] din0;
  logic [7:0]  din1, din2;
  logic [15:0] din3;
  logic        dout0, dout1, dout2, dout3;
  logic        rdy0, rdy1, rdy2, rdy3;
  logic        busy0, busy1, busy2, busy3;
  logic [2:0]  level0, level1, level2, level3;
  logic        ovf0, ovf1, ovf2, ovf3;

  uart_word_tx #(.DATA_WIDTH(32), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) u_plain (
    .clk(clk), .rst_n(rst_n), .en(en0), .data_in(din0), .dout(dout0),
    .rdy(rdy0), .busy(busy0), .level(level0), .overflow(ovf0));
  uart_word_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1)) u_even (
    .clk(clk), .rst_n(rst_n), .en(en1), .data_in(din1), .dout(dout1),
    .rdy(rdy1), .busy(busy1), .level(level1), .overflow(ovf1));
  uart_word_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .en(en2), .data_in(din2), .dout(dout2),
    .rdy(rdy2), .busy(busy2), .level(level2), .overflow(ovf2));
  uart_word_tx #(.DATA_WIDTH(16), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(2)) u_two_stop (
    .clk(clk), .rst_n(rst_n), .en(en3), .data_in(din3), .dout(dout3),
    .rdy(rdy3), .busy(busy3), .level(level3), .overflow(ovf3));

  int         sel;
  logic       dout_s, rdy_s, busy_s, ovf_s;
  logic [2:0] level_s;
  always_comb begin
    dout_s = dout0; rdy_s = rdy0; busy_s = busy0; ovf_s = ovf0; level_s = level0;
    case (sel)
      1: begin dout_s = dout1; rdy_s = rdy1; busy_s = busy1; ovf_s = ovf1; level_s = level1; end
      2: begin dout_s = dout2; rdy_s = rdy2; busy_s = busy2; ovf_s = ovf2; level_s = level2; end
      3: begin dout_s = dout3; rdy_s = rdy3; busy_s = busy3; ovf_s = ovf3; level_s = level3; end
      default: ;
    endcase
  end

  // Expected frames are bit-per-bit in send order: bit 0 = start bit.
  typedef struct {
    int               dut;
    logic [31:0]      data;
    int               nframes;
    int               nbits;
    logic [3:0][11:0] exp;
  } row_t;
  row_t rows[4];

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] rx_q[$];
  logic [7:0] exp_q[$];

  logic [31:0] fill_w[6] = '{32'h0F1E2D3C, 32'h11223344, 32'hA5C3E701,
                             32'h00FF00FF, 32'h80000001, 32'hDEADBEEF};
  int          fill_lvl[5] = '{1, 2, 3, 4, 4};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int s, input logic e, input logic [31:0] d);
    case (s)
      1: begin en1 = e; din1 = d[7:0]; end
      2: begin en2 = e; din2 = d[7:0]; end
      3: begin en3 = e; din3 = d[15:0]; end
      default: begin en0 = e; din0 = d; end
    endcase
  endtask

  // Called on the negedge where the start bit is first visible; returns on the
  // negedge where the following frame would begin.
  task automatic check_frame(input string name, input int nbits, input logic [11:0] exp);
    int   bad_at;
    logic bad_val;
    bad_at  = -1;
    bad_val = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < CPB; c++) begin
        if (bad_at < 0 && dout_s !== exp[k]) begin
          bad_at  = k * CPB + c;
          bad_val = dout_s;
        end
        @(negedge clk);
      end
    end
    n_cmp++;
    if (bad_at >= 0) begin
      n_bad++;
      $display("FAIL %s: clock %0d of frame dout=%b, expected %b", name, bad_at, bad_val, exp[bad_at / CPB]);
    end
  endtask

  task automatic expect_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic check_rx(input string name);
    check({name, "_byte_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_byte%0d", name, i), rx_q[i], {1'b1, exp_q[i]});
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (busy0 === 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_in_time"}, busy0, 0);
    @(negedge clk);
  endtask

  // Receiver on the plain instance: samples mid-bit, records {stop, data}.
  initial begin : rx_monitor
    logic [8:0] frame;
    bit         ok;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && dout0 === 1'b0) begin
        ok    = 1'b1;
        frame = '0;
        for (int c = 1; c < 10 * CPB; c++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            ok = 1'b0;
            break;
          end
          if (c % CPB == CPB / 2 && c / CPB >= 1) frame[c / CPB - 1] = dout0;
        end
        if (ok) rx_q.push_back(frame);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    sel = 0;
    en0 = 1'b0; en1 = 1'b0; en2 = 1'b0; en3 = 1'b0;
    din0 = '0; din1 = '0; din2 = '0; din3 = '0;

    rows[0].dut = 0; rows[0].data = 32'h51427963; rows[0].nframes = 4; rows[0].nbits = 10;
    rows[0].exp[0] = 12'h2C6; rows[0].exp[1] = 12'h2F2; rows[0].exp[2] = 12'h284; rows[0].exp[3] = 12'h2A2;
    rows[1].dut = 1; rows[1].data = 32'h63; rows[1].nframes = 1; rows[1].nbits = 11;
    rows[1].exp[0] = 12'h4C6; rows[1].exp[1] = '0; rows[1].exp[2] = '0; rows[1].exp[3] = '0;
    rows[2].dut = 2; rows[2].data = 32'h63; rows[2].nframes = 1; rows[2].nbits = 11;
    rows[2].exp[0] = 12'h6C6; rows[2].exp[1] = '0; rows[2].exp[2] = '0; rows[2].exp[3] = '0;
    rows[3].dut = 3; rows[3].data = 32'hA55A; rows[3].nframes = 2; rows[3].nbits = 11;
    rows[3].exp[0] = 12'h6B4; rows[3].exp[1] = 12'h74A; rows[3].exp[2] = '0; rows[3].exp[3] = '0;

    // Reset takes effect before the first clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("reset_dout", dout0, 1);
    check("reset_rdy", rdy0, 1);
    check("reset_busy", busy0, 0);
    check("reset_level", level0, 0);
    check("reset_overflow", ovf0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int r = 0; r < 4; r++) begin
      sel = rows[r].dut;
      @(negedge clk);
      drive(sel, 1'b1, rows[r].data);
      @(posedge clk);
      @(negedge clk);
      drive(sel, 1'b0, 32'h0);
      check($sformatf("row%0d_level_after_push", r), level_s, 1);
      check($sformatf("row%0d_busy_after_push", r), busy_s, 1);
      check($sformatf("row%0d_dout_edge1", r), dout_s, 1);
      @(negedge clk);
      check($sformatf("row%0d_dout_edge2", r), dout_s, 1);
      @(negedge clk);
      check($sformatf("row%0d_start_edge3", r), dout_s, 0);
      check($sformatf("row%0d_level_after_pop", r), level_s, 0);
      for (int f = 0; f < rows[r].nframes; f++)
        check_frame($sformatf("row%0d_frame%0d", r, f), rows[r].nbits, rows[r].exp[f]);
      check($sformatf("row%0d_busy_end", r), busy_s, 0);
      check($sformatf("row%0d_dout_end", r), dout_s, 1);
      check($sformatf("row%0d_rdy_end", r), rdy_s, 1);
      check($sformatf("row%0d_overflow_end", r), ovf_s, 0);
      repeat (3) @(negedge clk);
    end
    sel = 0;
    rx_q.delete();

    // Fill while the first word is on the line: four fit, the fifth is dropped.
    @(negedge clk);
    en0 = 1'b1; din0 = fill_w[0];
    @(posedge clk);
    @(negedge clk);
    en0 = 1'b0;
    repeat (2) @(negedge clk);
    check("fill_first_start", dout0, 0);
    for (int i = 0; i < 5; i++) begin
      en0 = 1'b1; din0 = fill_w[i+1];
      @(posedge clk);
      @(negedge clk);
      check($sformatf("fill_level%0d", i), level0, fill_lvl[i]);
      check($sformatf("fill_rdy%0d", i), rdy0, (i >= 3) ? 0 : 1);
      check($sformatf("fill_overflow%0d", i), ovf0, (i == 4) ? 1 : 0);
    end
    en0 = 1'b0;
    repeat (154) @(negedge clk);
    check("fill_rdy_before_pop", rdy0, 0);
    check("fill_level_before_pop", level0, 4);
    @(negedge clk);
    check("fill_rdy_on_pop", rdy0, 1);
    check("fill_level_on_pop", level0, 3);
    check("fill_second_start", dout0, 0);
    wait_idle("fill", 1000);
    for (int i = 0; i < 5; i++) expect_word(fill_w[i]);
    check_rx("fill");
    check("fill_overflow_sticky", ovf0, 1);

    // Push coinciding with the idle pop and with a word-boundary pop at level 2.
    @(negedge clk);
    en0 = 1'b1; din0 = 32'hC0FFEE01;
    @(posedge clk);
    @(negedge clk);
    din0 = 32'h13579BDF;
    @(posedge clk);
    @(negedge clk);
    din0 = 32'h2468ACE0;
    check("pp_level_before_idle_pop", level0, 2);
    @(posedge clk);
    @(negedge clk);
    en0 = 1'b0;
    check("pp_level_idle_pop", level0, 2);
    check("pp_start_idle_pop", dout0, 0);
    repeat (159) @(negedge clk);
    check("pp_level_before_word_pop", level0, 2);
    check("pp_stop_before_word_pop", dout0, 1);
    en0 = 1'b1; din0 = 32'h7E5A3C18;
    @(posedge clk);
    @(negedge clk);
    en0 = 1'b0;
    check("pp_level_word_pop", level0, 2);
    check("pp_start_word_pop", dout0, 0);
    wait_idle("pp", 1000);
    expect_word(32'hC0FFEE01);
    expect_word(32'h13579BDF);
    expect_word(32'h2468ACE0);
    expect_word(32'h7E5A3C18);
    check_rx("pp");

    // Reset in the data bits of the second byte with another word still queued.
    @(negedge clk);
    en0 = 1'b1; din0 = 32'h89ABCDEF;
    @(posedge clk);
    @(negedge clk);
    din0 = 32'h01234567;
    @(posedge clk);
    @(negedge clk);
    en0 = 1'b0;
    @(negedge clk);
    check("rst_first_start", dout0, 0);
    check("rst_level_queued", level0, 1);
    repeat (50) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_dout", dout0, 1);
    check("rst_mid_level", level0, 0);
    check("rst_mid_busy", busy0, 0);
    check("rst_mid_rdy", rdy0, 1);
    check("rst_mid_overflow", ovf0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    en0 = 1'b1; din0 = 32'h5EED0042;
    rx_q.delete();
    @(posedge clk);
    @(negedge clk);
    en0 = 1'b0;
    check("rst_accept_first_edge", level0, 1);
    @(negedge clk);
    check("rst_new_dout_edge2", dout0, 1);
    @(negedge clk);
    check("rst_new_start_edge3", dout0, 0);
    wait_idle("rst", 400);
    expect_word(32'h5EED0042);
    check_rx("rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
